// File: rtl/counter_pkg.sv
// Shared definitions for the counter block.
// Provides the default count width and a matching count type that
// neighbouring logic and benches can use to hold count values.
package counter_pkg;

    localparam int COUNT_W = 8;

    typedef logic [COUNT_W-1:0] count_t;

endpackage : counter_pkg

// File: rtl/counter_4_if.sv
// Control/data bundle between a counter controller and counter_4.
// Signals:
//   l    load strobe, active-high, sampled on the rising clock edge
//   s_s  start/stop: 1 = count enabled, 0 = hold
//   d    parallel load value
//   c    current registered count value
// Modports:
//   master  drives l, s_s and d; observes c
//   slave   the counter itself; receives l, s_s and d; drives c
interface counter_4_if
    import counter_pkg::*;
#(
    parameter int WIDTH = COUNT_W
);

    logic             l;
    logic             s_s;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] c;

    modport master (
        output l,
        output s_s,
        output d,
        input  c
    );

    modport slave (
        input  l,
        input  s_s,
        input  d,
        output c
    );

endinterface : counter_4_if

// File: rtl/counter_4.sv
// Loadable, start/stop-controlled binary up-counter.
// Serves as a general event/time-base counter: a start value can be
// preloaded, counting can be run or paused, and the count is readable
// at all times.
// Ports:
//   clk  system clock; all state updates on the rising edge
//   clr  asynchronous active-low reset; forces the count to zero at once
//   bus  counter_4_if.slave: l (load), s_s (start/stop), d (load data),
//        c (registered count output)
// Per-edge priority when out of reset: load, then count, then hold.
// The count wraps modulo 2^WIDTH with no flag and no saturation.
module counter_4
    import counter_pkg::*;
#(
    parameter int WIDTH = COUNT_W
) (
    input  logic         clk,
    input  logic         clr,
    counter_4_if.slave   bus
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] c_q;
    logic [WIDTH-1:0] c_next;

    // Load wins over count, so a load in the same cycle as s_s=1 produces
    // no increment; counting resumes from d on the following edge.
    always_comb begin
        c_next = c_q;
        if (bus.l) begin
            c_next = bus.d;
        end else if (bus.s_s) begin
            c_next = c_q + ONE;
        end
    end

    // Reset takes effect immediately and masks anything on l/s_s/d,
    // including a load that was about to be captured.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            c_q <= '0;
        end else begin
            c_q <= c_next;
        end
    end

    // Direct register output: no combinational path from inputs to c.
    assign bus.c = c_q;

endmodule : counter_4

// File: tb/tb_counter_4.sv
// Directed bench for counter_4: async reset, hold, count, stop/restart,
// load while counting, wrap-around and load while stopped. Every clock
// is also compared against a behavioural reference of the next-state rule.
module tb_counter_4;
    import counter_pkg::*;

    logic   clk;
    logic   clr;
    count_t c_ref;
    int     n_tests;
    int     n_fail;

    counter_4_if #(.WIDTH(COUNT_W)) bus_if ();

    counter_4 #(.WIDTH(COUNT_W)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference next-state rule.
    always @(posedge clk or negedge clr) begin
        if (!clr)
            c_ref <= '0;
        else if (bus_if.l)
            c_ref <= bus_if.d;
        else if (bus_if.s_s)
            c_ref <= c_ref + 8'd1;
    end

    task automatic check(input string tag, input count_t got, input count_t exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock and compare against the reference model.
    task automatic tick();
        @(posedge clk);
        #1;
        check("model", bus_if.c, c_ref);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        clr        = 1'b0;
        bus_if.l   = 1'b0;
        bus_if.s_s = 1'b0;
        bus_if.d   = '0;

        // Reset state
        #12;
        check("reset_init", bus_if.c, 8'h00);

        // Release and preload 0x3C
        @(negedge clk);
        clr      = 1'b1;
        bus_if.l = 1'b1;
        bus_if.d = 8'h3C;
        tick();
        bus_if.l = 1'b0;
        check("preload_3c", bus_if.c, 8'h3C);

        // Async reset mid-cycle: c clears before the next edge
        #2;
        clr = 1'b0;
        #1;
        check("async_clr", bus_if.c, 8'h00);
        bus_if.s_s = 1'b1;
        bus_if.l   = 1'b1;
        bus_if.d   = 8'hAA;
        tick();
        check("clr_hold_1", bus_if.c, 8'h00);
        tick();
        check("clr_hold_2", bus_if.c, 8'h00);

        // Hold: s_s=0, l=0, d=0xF0
        @(negedge clk);
        clr        = 1'b1;
        bus_if.l   = 1'b0;
        bus_if.s_s = 1'b0;
        bus_if.d   = 8'hF0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_zero", bus_if.c, 8'h00);
        end

        // Count 37 clocks, stop 10, resume 3
        bus_if.s_s = 1'b1;
        ticks(37);
        check("count_37", bus_if.c, 8'h25);
        bus_if.s_s = 1'b0;
        ticks(10);
        check("stop_10", bus_if.c, 8'h25);
        bus_if.s_s = 1'b1;
        ticks(3);
        check("resume_3", bus_if.c, 8'h28);

        // Load while counting: no increment while l=1, then resume from d
        bus_if.d = 8'hF0;
        bus_if.l = 1'b1;
        tick();
        check("load_run_1", bus_if.c, 8'hF0);
        tick();
        check("load_run_2", bus_if.c, 8'hF0);
        bus_if.l = 1'b0;
        tick();
        check("run_f1", bus_if.c, 8'hF1);
        tick();
        check("run_f2", bus_if.c, 8'hF2);

        // Wrap-around
        bus_if.s_s = 1'b0;
        bus_if.l   = 1'b1;
        bus_if.d   = 8'hFE;
        tick();
        check("load_fe", bus_if.c, 8'hFE);
        bus_if.l   = 1'b0;
        bus_if.s_s = 1'b1;
        tick();
        check("wrap_ff", bus_if.c, 8'hFF);
        tick();
        check("wrap_00", bus_if.c, 8'h00);
        tick();
        check("wrap_01", bus_if.c, 8'h01);

        // Load while stopped
        bus_if.s_s = 1'b0;
        bus_if.l   = 1'b1;
        bus_if.d   = 8'h5A;
        tick();
        check("load_stop", bus_if.c, 8'h5A);
        bus_if.l = 1'b0;
        bus_if.d = 8'h11;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_5a", bus_if.c, 8'h5A);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Safety bound so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout: got no finish, expected finish before 100000");
        $fatal(1, "timeout");
    end

endmodule : tb_counter_4
